// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the GPIO bank: register byte offsets and the word-index type.
// The word index is byte offset bits [4:2].
package gpio_bank_pkg;

    localparam logic [4:0] OFF_OUT      = 5'h00;
    localparam logic [4:0] OFF_DIR      = 5'h04;
    localparam logic [4:0] OFF_IN       = 5'h08;
    localparam logic [4:0] OFF_SET      = 5'h0C;
    localparam logic [4:0] OFF_CLR      = 5'h10;
    localparam logic [4:0] OFF_TGL      = 5'h14;
    localparam logic [4:0] OFF_IRQ_EN   = 5'h18;
    localparam logic [4:0] OFF_IRQ_STAT = 5'h1C;

    typedef enum logic [2:0] {
        REG_OUT      = 3'd0,
        REG_DIR      = 3'd1,
        REG_IN       = 3'd2,
        REG_SET      = 3'd3,
        REG_CLR      = 3'd4,
        REG_TGL      = 3'd5,
        REG_IRQ_EN   = 3'd6,
        REG_IRQ_STAT = 3'd7
    } reg_idx_t;

    function automatic reg_idx_t addr_to_idx(input logic [4:0] addr);
        return reg_idx_t'(addr[4:2]);
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-flop synchronizer for asynchronous pins, plus a one-cycle delay copy
// used to flag rising edges on the synchronized value.
module gpio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_r;
    logic [WIDTH-1:0]                  dly_r;

    // Synchronizer shift chain and delayed copy of the final stage.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stage_r <= '0;
            dly_r   <= '0;
        end else begin
            stage_r <= {stage_r[SYNC_STAGES-2:0], i_async};
            dly_r   <= stage_r[SYNC_STAGES-1];
        end
    end

    assign o_sync = stage_r[SYNC_STAGES-1];
    assign o_rise = stage_r[SYNC_STAGES-1] & ~dly_r;

endmodule

// File: rtl/gpio_bank_ip.sv
// Memory-mapped GPIO bank: output/direction registers with set/clear/toggle
// aliases, synchronized input readback, and rising-edge interrupts.
module gpio_bank_ip
    import gpio_bank_pkg::*;
#(
    parameter int N_GPIO      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_sel,
    input  logic              i_we,
    input  logic [4:0]        i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    input  logic [N_GPIO-1:0] i_gpio_in,
    output logic [N_GPIO-1:0] o_gpio_out,
    output logic [N_GPIO-1:0] o_gpio_oe,
    output logic              o_irq
);

    localparam logic [2:0] ARM_LIMIT = 3'(SYNC_STAGES + 1);

    logic [N_GPIO-1:0] out_r, dir_r, en_r, stat_r;
    logic [N_GPIO-1:0] out_nxt_s, dir_nxt_s, en_nxt_s, stat_nxt_s;
    logic [N_GPIO-1:0] w1c_s, sync_s, rise_s, wdata_s;
    logic [2:0]        arm_cnt_r;
    logic              armed_s, wr_s, unused_s;
    reg_idx_t          idx_s;
    logic [31:0]       rdata_s;

    gpio_sync_edge #(
        .WIDTH       (N_GPIO),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .resetn  (resetn),
        .i_async (i_gpio_in),
        .o_sync  (sync_s),
        .o_rise  (rise_s)
    );

    assign idx_s    = addr_to_idx(i_addr);
    assign wr_s     = i_sel & i_we;
    assign wdata_s  = i_wdata[N_GPIO-1:0];
    assign armed_s  = (arm_cnt_r == ARM_LIMIT);
    assign unused_s = ^{i_addr[1:0], i_wdata};

    // Next-state for the register file; interrupt set beats a same-cycle W1C.
    always_comb begin
        out_nxt_s = out_r;
        dir_nxt_s = dir_r;
        en_nxt_s  = en_r;
        w1c_s     = '0;
        if (wr_s) begin
            case (idx_s)
                REG_OUT:      out_nxt_s = wdata_s;
                REG_DIR:      dir_nxt_s = wdata_s;
                REG_SET:      out_nxt_s = out_r | wdata_s;
                REG_CLR:      out_nxt_s = out_r & ~wdata_s;
                REG_TGL:      out_nxt_s = out_r ^ wdata_s;
                REG_IRQ_EN:   en_nxt_s  = wdata_s;
                REG_IRQ_STAT: w1c_s     = wdata_s;
                default:      out_nxt_s = out_r;
            endcase
        end else begin
            w1c_s = '0;
        end
        stat_nxt_s = (stat_r & ~w1c_s) | (rise_s & en_r & {N_GPIO{armed_s}});
    end

    // Register state and the post-reset arm counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_r     <= '0;
            dir_r     <= '0;
            en_r      <= '0;
            stat_r    <= '0;
            arm_cnt_r <= 3'd0;
        end else begin
            out_r  <= out_nxt_s;
            dir_r  <= dir_nxt_s;
            en_r   <= en_nxt_s;
            stat_r <= stat_nxt_s;
            if (!armed_s) begin
                arm_cnt_r <= arm_cnt_r + 3'd1;
            end else begin
                arm_cnt_r <= arm_cnt_r;
            end
        end
    end

    // Read mux; write-only offsets and deselected accesses read as zero.
    always_comb begin
        rdata_s = 32'd0;
        if (i_sel) begin
            case (idx_s)
                REG_OUT:      rdata_s[N_GPIO-1:0] = out_r;
                REG_DIR:      rdata_s[N_GPIO-1:0] = dir_r;
                REG_IN:       rdata_s[N_GPIO-1:0] = sync_s;
                REG_IRQ_EN:   rdata_s[N_GPIO-1:0] = en_r;
                REG_IRQ_STAT: rdata_s[N_GPIO-1:0] = stat_r;
                default:      rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign o_rdata    = rdata_s;
    assign o_gpio_out = out_r;
    assign o_gpio_oe  = dir_r;
    assign o_irq      = |(stat_r & en_r);

endmodule

// File: tb/tb_gpio_bank_ip.sv
// Directed self-checking bench for gpio_bank_ip with N_GPIO=8, SYNC_STAGES=2.
module tb_gpio_bank_ip;
    import gpio_bank_pkg::*;

    logic        clk;
    logic        resetn;
    logic        i_sel;
    logic        i_we;
    logic [4:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic [7:0]  i_gpio_in;
    logic [7:0]  o_gpio_out;
    logic [7:0]  o_gpio_oe;
    logic        o_irq;

    int n_cmp;
    int n_err;

    gpio_bank_ip #(.N_GPIO(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_sel      (i_sel),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .i_gpio_in  (i_gpio_in),
        .o_gpio_out (o_gpio_out),
        .o_gpio_oe  (o_gpio_oe),
        .o_irq      (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        i_sel   = 1'b1;
        i_we    = 1'b1;
        i_addr  = a;
        i_wdata = d;
        tick();
        i_sel   = 1'b0;
        i_we    = 1'b0;
        i_addr  = 5'h00;
        i_wdata = 32'h0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        i_sel  = 1'b1;
        i_we   = 1'b0;
        i_addr = a;
        #1;
        d      = o_rdata;
        i_sel  = 1'b0;
        i_addr = 5'h00;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        resetn = 1'b0;
        repeat (3) tick();
        n_cmp++; if (o_gpio_out !== 8'h00) begin n_err++; $display("FAIL reset_out: got %h want 00", o_gpio_out); end
        n_cmp++; if (o_gpio_oe !== 8'h00) begin n_err++; $display("FAIL reset_oe: got %h want 00", o_gpio_oe); end
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", o_irq); end
        n_cmp++; if (o_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata_nosel: got %h want 0", o_rdata); end
        rd(OFF_IRQ_EN, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_irq_en: got %h want 0", d); end
        rd(OFF_IRQ_STAT, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_irq_stat: got %h want 0", d); end
        resetn = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_out_ops();
        logic [31:0] d;
        logic [4:0]  addr_tab [4];
        logic [7:0]  data_tab [4];
        logic [7:0]  exp_tab  [4];
        addr_tab = '{OFF_OUT, OFF_SET, OFF_CLR, OFF_TGL};
        data_tab = '{8'hA5, 8'h0F, 8'h80, 8'h03};
        exp_tab  = '{8'hA5, 8'hAF, 8'h2F, 8'h2C};
        for (int i = 0; i < 4; i++) begin
            wr(addr_tab[i], {24'h0, data_tab[i]});
            n_cmp++; if (o_gpio_out !== exp_tab[i]) begin n_err++; $display("FAIL out_step%0d: got %h want %h", i, o_gpio_out, exp_tab[i]); end
            rd(OFF_OUT, d);
            n_cmp++; if (d !== {24'h0, exp_tab[i]}) begin n_err++; $display("FAIL out_rb%0d: got %h want %h", i, d, {24'h0, exp_tab[i]}); end
        end
    endtask

    task automatic test_dir_and_unmapped();
        logic [31:0] d;
        wr(OFF_DIR, 32'hFFFF_FFFF);
        n_cmp++; if (o_gpio_oe !== 8'hFF) begin n_err++; $display("FAIL dir_oe: got %h want ff", o_gpio_oe); end
        rd(OFF_DIR, d);
        n_cmp++; if (d !== 32'h0000_00FF) begin n_err++; $display("FAIL dir_rb: got %h want 000000ff", d); end
        wr(OFF_IN, 32'hFFFF_FFFF);
        n_cmp++; if (o_gpio_out !== 8'h2C) begin n_err++; $display("FAIL in_wr_out: got %h want 2c", o_gpio_out); end
        rd(OFF_IN, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL in_wr_in: got %h want 0", d); end
        rd(OFF_IRQ_EN, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL in_wr_en: got %h want 0", d); end
        rd(OFF_SET, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rd_set: got %h want 0", d); end
        tick();
        rd(OFF_CLR, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rd_clr: got %h want 0", d); end
        rd(OFF_TGL, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rd_tgl: got %h want 0", d); end
        i_addr = OFF_OUT;
        #1;
        n_cmp++; if (o_rdata !== 32'h0) begin n_err++; $display("FAIL rd_nosel: got %h want 0", o_rdata); end
        i_addr = 5'h00;
    endtask

    task automatic test_irq_edge();
        logic [31:0] d;
        wr(OFF_IRQ_EN, 32'h10);
        i_gpio_in = 8'h10;
        tick();
        rd(OFF_IN, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL in_lat1: got %h want 0", d); end
        tick();
        rd(OFF_IN, d);
        n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL in_lat2: got %h want 10", d); end
        rd(OFF_IRQ_STAT, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL stat_early: got %h want 0", d); end
        tick();
        rd(OFF_IRQ_STAT, d);
        n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL stat_set: got %h want 10", d); end
        n_cmp++; if (o_irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b want 1", o_irq); end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        i_gpio_in = 8'h00;
        repeat (4) tick();
        i_gpio_in = 8'h10;
        tick();
        tick();
        wr(OFF_IRQ_STAT, 32'h10);
        rd(OFF_IRQ_STAT, d);
        n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL set_wins: got %h want 10", d); end
        wr(OFF_IRQ_EN, 32'h0);
        rd(OFF_IRQ_STAT, d);
        n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL en_clr_keeps_stat: got %h want 10", d); end
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL irq_masked: got %b want 0", o_irq); end
        wr(OFF_IRQ_EN, 32'h10);
        n_cmp++; if (o_irq !== 1'b1) begin n_err++; $display("FAIL irq_unmasked: got %b want 1", o_irq); end
        wr(OFF_IRQ_STAT, 32'h10);
        rd(OFF_IRQ_STAT, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL w1c: got %h want 0", d); end
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL irq_w1c: got %b want 0", o_irq); end
    endtask

    task automatic test_reset_arm();
        logic [31:0] d;
        i_gpio_in = 8'hFF;
        resetn    = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        wr(OFF_IRQ_EN, 32'hFF);
        repeat (5) tick();
        rd(OFF_IRQ_STAT, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL arm_stat: got %h want 0", d); end
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL arm_irq: got %b want 0", o_irq); end
        rd(OFF_IN, d);
        n_cmp++; if (d !== 32'hFF) begin n_err++; $display("FAIL arm_in: got %h want ff", d); end
    endtask

    task automatic test_reset_write();
        logic [31:0] d;
        wr(OFF_DIR, 32'hFF);
        wr(OFF_OUT, 32'h0F);
        resetn  = 1'b0;
        i_sel   = 1'b1;
        i_we    = 1'b1;
        i_addr  = OFF_OUT;
        i_wdata = 32'h55;
        tick();
        i_sel   = 1'b0;
        i_we    = 1'b0;
        i_wdata = 32'h0;
        n_cmp++; if (o_gpio_out !== 8'h00) begin n_err++; $display("FAIL rstwr_out: got %h want 00", o_gpio_out); end
        n_cmp++; if (o_gpio_oe !== 8'h00) begin n_err++; $display("FAIL rstwr_oe: got %h want 00", o_gpio_oe); end
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL rstwr_irq: got %b want 0", o_irq); end
        rd(OFF_IRQ_EN, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rstwr_en: got %h want 0", d); end
        resetn = 1'b1;
        tick();
        rd(OFF_OUT, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rstwr_rb: got %h want 0", d); end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        resetn    = 1'b0;
        i_sel     = 1'b0;
        i_we      = 1'b0;
        i_addr    = 5'h00;
        i_wdata   = 32'h0;
        i_gpio_in = 8'h00;
        test_reset();
        test_out_ops();
        test_dir_and_unmapped();
        test_irq_edge();
        test_set_wins();
        test_reset_arm();
        test_reset_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
